// File: rtl/jpeg_seq_pkg.sv
// Shared types and default geometry for the 8x8 DCT pipeline frame sequencer.
package jpeg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    localparam int DEF_ROW_W   = 3;
    localparam int DEF_NSTAGE  = 3;
    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_OUT_LAT = 27;

    // Stage k offset lives in bits [k*ADDR_W +: ADDR_W]; stage 0 is the LSB slice.
    localparam logic [DEF_NSTAGE*DEF_ADDR_W-1:0] DEF_STAGE_OFS = {15'd18, 15'd9, 15'd0};

endpackage

// File: rtl/stage_phase.sv
// One ping-pong stage: decides when the stage is live and which bank it uses,
// holding the last bank once the frame has moved past it.
module stage_phase #(
    parameter int                ROW_W  = 3,
    parameter int                ADDR_W = 15,
    parameter logic [ADDR_W-1:0] OFS    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            hold,
    input  logic            in_frame,
    input  logic [ADDR_W:0] cyc,
    input  logic [ADDR_W-1:0] len,
    output logic            stage_act,
    output logic            bank_sel
);
    localparam int                CYC_W = ADDR_W + 1;
    localparam logic [CYC_W-1:0] OFS_C  = CYC_W'(OFS);
    localparam logic [CYC_W-1:0] PHASE_MASK = CYC_W'(1) << ROW_W;

    logic [CYC_W-1:0] end_c;
    logic [CYC_W-1:0] rel;
    logic             bank_q;

    // Stage window and block phase relative to this stage's offset.
    always_comb begin
        end_c     = {1'b0, len} + OFS_C;
        rel       = cyc - OFS_C;
        stage_act = in_frame && (cyc >= OFS_C) && (cyc < end_c);
        bank_sel  = stage_act ? ~(|(rel & PHASE_MASK)) : bank_q;
    end

    // Remember the bank so it stays put outside the active window; a new frame re-arms it to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_q <= 1'b1;
        end else if (load) begin
            bank_q <= 1'b1;
        end else if (!hold) begin
            bank_q <= bank_sel;
        end
    end

endmodule

// File: rtl/jpeg_pipe_sequencer.sv
// Frame sequencer for the DCT/quantise/zig-zag pipeline: one cycle counter drives
// the input read address, every stage bank select and the delayed output write.
module jpeg_pipe_sequencer
    import jpeg_seq_pkg::*;
#(
    parameter int                         ROW_W     = DEF_ROW_W,
    parameter int                         NSTAGE    = DEF_NSTAGE,
    parameter int                         ADDR_W    = DEF_ADDR_W,
    parameter logic [NSTAGE*ADDR_W-1:0]   STAGE_OFS = DEF_STAGE_OFS,
    parameter int                         OUT_LAT   = DEF_OUT_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_rows,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  row_idx,
    output logic [NSTAGE-1:0] bank_sel,
    output logic [NSTAGE-1:0] stage_act,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);
    localparam int               CYC_W = ADDR_W + 1;
    localparam logic [CYC_W-1:0] LAT_C = CYC_W'(OUT_LAT);

    seq_state_e        state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [ADDR_W-1:0] len_q;
    logic              busy_q;
    logic              done_q;

    logic [CYC_W-1:0]  len_ext;
    logic [CYC_W-1:0]  lat_end;
    logic              in_frame;
    logic              wr_win;
    logic              load;

    // Frame bounds derived from the latched length; cyc never wraps for legal sizes.
    always_comb begin
        len_ext  = {1'b0, len_q};
        lat_end  = len_ext + LAT_C;
        in_frame = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        wr_win   = in_frame && (cyc_q >= LAT_C) && (cyc_q < lat_end);
        load     = (state_q == ST_IDLE) && start;
    end

    // Sequencer FSM: start/len capture, counter advance, drain and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= frame_rows;
                        cyc_q <= '0;
                        if (frame_rows == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        cyc_q <= cyc_q + 1'b1;
                        if (cyc_q == len_ext - 1'b1) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        cyc_q <= cyc_q + 1'b1;
                        if (cyc_q == lat_end - 1'b1) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes depend only on registered state and stall.
    always_comb begin
        rd_en   = (state_q == ST_RUN) && !stall;
        rd_addr = ADDR_W'(cyc_q);
        row_idx = ROW_W'(cyc_q);
        wr_en   = wr_win && !stall;
        wr_addr = wr_win ? ADDR_W'(cyc_q - LAT_C) : '0;
        busy    = busy_q;
        done    = done_q;
    end

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
            stage_phase #(
                .ROW_W  (ROW_W),
                .ADDR_W (ADDR_W),
                .OFS    (STAGE_OFS[gi*ADDR_W +: ADDR_W])
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .load      (load),
                .hold      (stall),
                .in_frame  (in_frame),
                .cyc       (cyc_q),
                .len       (len_q),
                .stage_act (stage_act[gi]),
                .bank_sel  (bank_sel[gi])
            );
        end
    endgenerate

endmodule

// File: doc/jpeg_pipe_sequencer.md
# jpeg_pipe_sequencer

Parametrised frame sequencer for the 8x8 DCT/quantise/zig-zag pipeline. It generates the input-memory read address, one ping-pong bank select per transpose/reorder stage, and the delayed output-memory write address from a single cycle counter. Unlike the free-running counter plus fixed-offset toggles it replaces, it adds a start/done handshake, a programmable frame length, a global stall, configurable block size, stage count, per-stage offsets and output latency, and a clean stop at end of frame. It sits at the top level beside the input/output SRAMs and drives every pipeline-stage enable.

## Interface
- ROW_W, 3: log2 of rows per block; the bank toggles every 2^ROW_W active cycles.
- NSTAGE, 3: number of ping-pong stages.
- ADDR_W, 15: memory address width.
- STAGE_OFS, {15'd18,15'd9,15'd0}: packed NSTAGE*ADDR_W bits; stage k offset is [k*ADDR_W +: ADDR_W].
- OUT_LAT, 27: cycles from a read to the write of the same row; must be at least the largest STAGE_OFS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- frame_rows  in  ADDR_W  row beats in the frame; sampled on an accepted start.
- stall  in  1  freezes the whole sequence while high.
- rd_en  out  1  input-memory read strobe.
- rd_addr  out  ADDR_W  input-memory address.
- row_idx  out  ROW_W  row within the current input block (rd_addr[ROW_W-1:0]).
- bank_sel  out  NSTAGE  per-stage ping-pong select.
- stage_act  out  NSTAGE  per-stage active flag.
- wr_en  out  1  output-memory write strobe.
- wr_addr  out  ADDR_W  output-memory address.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle end-of-frame pulse.

## Operation
- States:
  - IDLE: start=1 latches frame_rows into len, clears cyc and sets bank_sel to all ones; goes to RUN (len>0) or DONE (len=0).
  - RUN: cyc advances by 1 each non-stalled cycle; moves to DRAIN when cyc=len-1 advances.
  - DRAIN: cyc keeps advancing; moves to DONE when cyc=len+OUT_LAT-1 advances.
  - DONE: done=1 for one cycle, then IDLE.
- cyc is ADDR_W+1 bits wide; its arithmetic never wraps for legal parameters.
- Read side: rd_en = RUN & ~stall; rd_addr = cyc[ADDR_W-1:0].
- Stage k:
  - Active while STAGE_OFS[k] <= cyc < len+STAGE_OFS[k], in RUN or DRAIN.
  - bank_sel[k] = ~(((cyc-STAGE_OFS[k]) >> ROW_W) & 1) while active, so it is 1 for the first block.
  - When inactive, bank_sel[k] holds its last value.
- Write side: wr_en = (OUT_LAT <= cyc < len+OUT_LAT) & ~stall; wr_addr = cyc-OUT_LAT.
- Stall: cyc, state and bank_sel all hold, and rd_en and wr_en are 0 in that same cycle. done is not delayed by stall once in DONE.
- A partial final block (len not a multiple of 2^ROW_W) is legal; the sequence stops at len exactly.
- start during busy or DONE: ignored, no effect.

## Timing
- Reset values: state IDLE; cyc, len, rd_addr, wr_addr, rd_en, wr_en, stage_act, busy, done all 0; bank_sel all ones.
- Reset asserted mid-frame aborts at once to the reset values; no done pulse.
- Accepted start at edge t: from t+1, busy=1, rd_en=1, rd_addr=0.
- Row r: read at non-stalled active cycle r, written OUT_LAT active cycles later.
- With no stall, done is high exactly len+OUT_LAT+1 cycles after the start edge; busy=0 in the done cycle.
- The only combinational inputs to rd_en and wr_en are stall and registered state; no input-to-output path through start or frame_rows.

## Structure
- Package jpeg_seq_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default ROW_W, ADDR_W and OUT_LAT;
  - the default offset vector.
- Sub-module stage_phase generates one stage's stage_act and bank_sel from cyc, len and its offset. It is instantiated NSTAGE times in a generate loop.

## Test plan
All scenarios use the default parameters unless stated.
- Normal frame: frame_rows=64, start pulse, no stall:
  - rd_addr runs 0..63;
  - bank_sel[0] is 1 for cycles 0-7, 0 for 8-15, then keeps toggling;
  - bank_sel[1] first toggles at cyc=17;
  - wr_en first at cyc=27 with wr_addr=0, last at cyc=90 with wr_addr=63;
  - done 92 cycles after start.
- Stall: stall 5 cycles at cyc=30, then a 1-cycle stall during DRAIN:
  - no rd_en/wr_en during stalls;
  - addresses resume unchanged with no gaps or duplicates;
  - done is delayed by exactly 6 cycles.
- Zero and partial frames:
  - frame_rows=0: done one cycle after start, with no rd_en or wr_en;
  - frame_rows=13: 13 reads and 13 writes, and bank_sel[0] ends at 0.
- start ignored: a second start at cyc=10 with frame_rows=5 changes nothing; the original frame of 64 completes.
- Reset: reset low at cyc=40 gives all outputs at reset values within the same cycle; a later start runs a clean new frame from rd_addr=0.
- Parameter sweep: ROW_W=2, NSTAGE=4, offsets {12,8,4,0}, OUT_LAT=20, frame_rows=16:
  - bank toggles every 4 cycles per stage, starting at the stage offset;
  - wr_en spans cyc 20-35.
